// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control front end for a stopwatch datapath. Three raw push-buttons are
// synchronised, debounced and edge-detected into single-cycle press events,
// which drive a STOP/RUN/CLEAR state machine and a lap-hold toggle.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_run,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic       run,
   output logic       clear,
   output logic       lap_hold,
   output logic [1:0] state
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Button lanes: bit 0 = run, bit 1 = clear, bit 2 = lap
   localparam int BTN_RUN = 0;
   localparam int BTN_CLR = 1;
   localparam int BTN_LAP = 2;

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_CLEAR = 2'b10
   } state_t;

   logic [2:0]       btn_s;
   logic [2:0]       sync1_r;
   logic [2:0]       sync2_r;
   logic [2:0]       stable_r;
   logic [2:0]       stable_d_r;
   logic [CNT_W-1:0] cnt_r [3];
   logic [2:0]       press_s;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             lap_nxt_s;
   logic             lap_hold_r;
   logic             run_r;
   logic             clear_r;

   assign btn_s = {btn_lap, btn_clear, btn_run};

   // Two-flop synchronisers bring each raw button into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
      end
   end

   // Debouncers: accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
               stable_r[i] <= sync2_r[i];
               cnt_r[i]    <= CNT_ZERO;
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   // Delayed copy of the stable levels for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_r <= 3'b000;
      end else begin
         stable_d_r <= stable_r;
      end
   end

   // A press is the first cycle a stable level is high; releases make no event
   assign press_s = stable_r & ~stable_d_r;

   // Next-state and lap-hold decisions from the current state and press events
   always_comb begin
      state_nxt_s = state_r;
      lap_nxt_s   = lap_hold_r;
      case (state_r)
         ST_STOP: begin
            if (press_s[BTN_CLR]) begin
               state_nxt_s = ST_CLEAR;
            end else if (press_s[BTN_RUN]) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         ST_RUN: begin
            if (press_s[BTN_RUN]) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_nxt_s = ST_STOP;
         end
         default: begin
            state_nxt_s = ST_STOP;
         end
      endcase

      // Entering CLEAR wins over any coincident lap press
      if (state_nxt_s == ST_CLEAR) begin
         lap_nxt_s = 1'b0;
      end else if ((state_r != ST_CLEAR) && press_s[BTN_LAP]) begin
         lap_nxt_s = ~lap_hold_r;
      end else begin
         lap_nxt_s = lap_hold_r;
      end
   end

   // State register plus registered Moore decodes of the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_STOP;
         run_r      <= 1'b0;
         clear_r    <= 1'b0;
         lap_hold_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         run_r      <= (state_nxt_s == ST_RUN);
         clear_r    <= (state_nxt_s == ST_CLEAR);
         lap_hold_r <= lap_nxt_s;
      end
   end

   assign run      = run_r;
   assign clear    = clear_r;
   assign lap_hold = lap_hold_r;
   assign state    = state_r;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 100_000, the number of clk cycles a button level must stay stable before it is accepted (1 ms at 100 MHz; minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port btn_run, input, 1 bit: raw run/stop push-button, asynchronous to clk, high = pressed.
REQ-005 The block SHALL have port btn_clear, input, 1 bit: raw clear push-button, asynchronous, high = pressed.
REQ-006 The block SHALL have port btn_lap, input, 1 bit: raw lap push-button, asynchronous, high = pressed.
REQ-007 The block SHALL have port run, output, 1 bit: enables time advance in the stopwatch datapath.
REQ-008 The block SHALL have port clear, output, 1 bit: zeroes the datapath counters and the divider.
REQ-009 The block SHALL have port lap_hold, output, 1 bit: freezes the displayed time while counting continues.
REQ-010 The block SHALL have port state, output, 2 bits: current FSM state, with 00 = STOP, 01 = RUN, 10 = CLEAR.

Function
REQ-011 Each button SHALL pass through its own two-flip-flop synchroniser before any other logic uses it.
REQ-012 Each button SHALL have an independent debouncer with the following behaviour:
- It holds a stable level and a counter of width $clog2(DEBOUNCE_CYCLES).
- While the synchronised level equals the stable level, the counter is held at 0.
- While the two levels differ, the counter increments once per cycle.
- On the cycle the counter equals DEBOUNCE_CYCLES-1, the stable level takes the synchronised value and the counter returns to 0.
REQ-013 A level difference that lasts fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change in the stable level.
REQ-014 A press event SHALL be a 1-cycle pulse generated on a 0->1 transition of the stable level, and a release (1->0) SHALL generate no event.
REQ-015 A held button SHALL produce exactly one press event regardless of how long it is held.
REQ-016 The FSM SHALL have three states: STOP, RUN and CLEAR.
REQ-017 In STOP, a clear event SHALL move the FSM to CLEAR; otherwise a run event SHALL move it to RUN; otherwise it SHALL remain in STOP.
REQ-018 In RUN, a run event SHALL move the FSM to STOP, and clear events SHALL be ignored.
REQ-019 The FSM SHALL stay in CLEAR for exactly one cycle and then go to STOP unconditionally, ignoring all events during that cycle.
REQ-020 If clear and run events coincide in STOP, clear SHALL take priority and the run event SHALL be discarded.
REQ-021 The outputs run and clear SHALL be Moore decodes of the state register:
- run = 1 only in RUN.
- clear = 1 only in CLEAR, as a single-cycle pulse.
REQ-022 A lap event SHALL toggle lap_hold only while the FSM is in RUN or STOP, and lap events SHALL be ignored in CLEAR.
REQ-023 lap_hold SHALL be forced to 0 on the cycle the FSM enters CLEAR, with 0 visible together with clear = 1.
REQ-024 lap_hold SHALL be unchanged by RUN<->STOP transitions.
REQ-025 A lap event coincident with a transition into CLEAR SHALL be discarded, so that lap_hold = 0.
REQ-026 Latency SHALL be as follows: for an input that rises and stays high, the output change SHALL be visible after exactly DEBOUNCE_CYCLES+3 rising clk edges, counting from the first edge that samples the high level.
REQ-027 Latency SHALL be identical for all three buttons.
REQ-028 Events from different buttons arriving on the same cycle SHALL all be processed in that cycle, following REQ-017 to REQ-025.

Reset
REQ-029 While reset_n = 0, the block SHALL asynchronously hold the following values:
- state = STOP, run = 0, clear = 0, lap_hold = 0.
- All synchroniser flops, stable levels, counters and edge detectors = 0.
REQ-030 A button already held high when reset_n deasserts SHALL generate one press event after normal debounce latency.
REQ-031 Reset asserted mid-operation, in any state or mid-debounce, SHALL abort immediately with no residual event after release.

Verification (DEBOUNCE_CYCLES = 4 for simulation)
REQ-032 Reset then press btn_run for 10 cycles: run = 1 and state = 01 from edge 7 after the first sampled-high edge; a second press gives run = 0 and state = 00.
REQ-033 Apply btn_run with 3-cycle high pulses separated by 1-cycle lows: no event occurs and run stays 0.
REQ-034 In RUN, press btn_clear: state stays 01 and clear stays 0; stop the watch, then press clear: clear = 1 for exactly 1 cycle, state goes 10 then 00, and lap_hold = 0.
REQ-035 In STOP, press btn_run and btn_clear on the same cycle: state goes to 10, then 00, and run is never 1.
REQ-036 In RUN, press btn_lap twice: lap_hold goes 1 then 0, while run stays 1 throughout.
REQ-037 In RUN with lap_hold = 1, pulse reset_n low for 1 cycle: all outputs go to 0 immediately, and no event follows while buttons are released.
